// File: rtl/riscv_mmio_uart_tx.sv
// -----------------------------------------------------------------------------
// riscv_mmio_uart_tx
//
// Memory-mapped UART transmitter for the multicycle core's data bus. Stores
// push bytes into a small TX FIFO and a single FSM serialises them as 8N1
// frames on tx. Reads are purely combinational and have no side effects,
// because the core provides no read strobe.
//
// Register window (BASE_ADDR, 16-byte aligned), byte offsets:
//   0x0 TXDATA   W: push wdata[7:0]            R: 0
//   0x4 STATUS   R: [0]full [1]empty [2]busy [3]overrun [7:4]count
//                W: wdata[3]=1 clears overrun
//   0x8 BAUDDIV  R/W [15:0]; bit period is BAUDDIV+1 clocks
//   0xC          reads 0, writes ignored
//
// Ports:
//   clk    in   rising-edge clock
//   reset  in   asynchronous, active-high
//   addr   in   byte address from the core; addr[1:0] ignored
//   wdata  in   store data
//   we     in   store strobe, sampled at posedge
//   rdata  out  combinational read data, 0 when hit=0
//   hit    out  combinational address match for the register window
//   tx     out  serial line, idle high, driven from a flop
//   irq    out  registered; 1 when the FIFO is empty and the shifter is idle
// -----------------------------------------------------------------------------
module riscv_mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR   = 32'hFFFF_FF00,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd867
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  output logic [31:0] rdata,
  output logic        hit,
  output logic        tx,
  output logic        irq
);

  localparam int               PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int               CNT_W    = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  // FIFO and register state
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overrun_q, overrun_d;
  logic [15:0]      bauddiv_q, bauddiv_d;

  // Transmit FSM state
  state_e      state_q;
  logic [7:0]  shift_q;
  logic [15:0] div_q;     // divisor latched at pop, fixed for the whole frame
  logic [15:0] baud_q;
  logic [2:0]  bit_q;
  logic        tx_q;
  logic        irq_q;

  logic [1:0] reg_sel;
  logic       wr_txdata, wr_status, wr_baud;
  logic       fifo_empty, fifo_full, busy, bit_end;
  logic       pop, push_ok;
  logic       unused_bits;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  assign hit       = (addr[31:4] == BASE_ADDR[31:4]);
  assign reg_sel   = addr[3:2];
  assign wr_txdata = we & hit & (reg_sel == 2'd0);
  assign wr_status = we & hit & (reg_sel == 2'd1);
  assign wr_baud   = we & hit & (reg_sel == 2'd2);

  assign unused_bits = ^{addr[1:0], wdata[31:16]};

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == DEPTH_C);
  assign busy       = (state_q != IDLE);
  assign bit_end    = (baud_q == div_q);

  // The FSM takes a byte whenever it is idle, or at the last clock of a stop
  // bit, so consecutive frames run with no idle gap.
  assign pop = ~fifo_empty & ((state_q == IDLE) | ((state_q == STOP) & bit_end));

  // A push into a full FIFO still fits if a byte leaves in the same clock.
  assign push_ok = wr_txdata & (~fifo_full | pop);

  // ---------------------------------------------------------------------------
  // FIFO / register next state
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    overrun_d = overrun_q;
    bauddiv_d = bauddiv_q;

    if (push_ok) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
    if (pop)     rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;

    case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Overrun is sticky until software writes STATUS with bit 3 set.
    if (wr_txdata & ~push_ok)      overrun_d = 1'b1;
    else if (wr_status & wdata[3]) overrun_d = 1'b0;

    if (wr_baud) bauddiv_d = wdata[15:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples the pre-edge values of the others.
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
      bauddiv_q <= DEFAULT_DIV;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
      bauddiv_q <= bauddiv_d;
    end
  end

  // NOTE: FIFO storage has no reset; count_q guards every read, so stale
  // contents are never observed and the array can map onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata[7:0];
  end

  // ---------------------------------------------------------------------------
  // Transmit FSM with registered tx and irq
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      div_q   <= DEFAULT_DIV;
      baud_q  <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
      irq_q   <= 1'b1;
    end else begin
      // tx follows the current state one clock later, so the start bit shows
      // on the line the clock after the pop.
      case (state_q)
        START:   tx_q <= 1'b0;
        DATA:    tx_q <= shift_q[0];
        default: tx_q <= 1'b1;
      endcase
      irq_q <= fifo_empty & ~busy;

      case (state_q)
        IDLE: begin
          if (pop) begin
            shift_q <= mem_q[rd_ptr_q];
            div_q   <= bauddiv_q;
            baud_q  <= '0;
            bit_q   <= '0;
            state_q <= START;
          end
        end
        START: begin
          if (bit_end) begin
            baud_q  <= '0;
            bit_q   <= '0;
            state_q <= DATA;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_q  <= '0;
            shift_q <= {1'b0, shift_q[7:1]};
            if (bit_q == 3'd7) state_q <= STOP;
            else               bit_q   <= bit_q + 1'b1;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            baud_q <= '0;
            if (pop) begin
              shift_q <= mem_q[rd_ptr_q];
              div_q   <= bauddiv_q;
              bit_q   <= '0;
              state_q <= START;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx  = tx_q;
  assign irq = irq_q;

  // ---------------------------------------------------------------------------
  // Combinational read mux
  // ---------------------------------------------------------------------------
  always_comb begin
    rdata = '0;
    if (hit) begin
      case (reg_sel)
        2'd1:    rdata[7:0]  = {4'(count_q), overrun_q, busy, fifo_empty, fifo_full};
        2'd2:    rdata[15:0] = bauddiv_q;
        default: rdata       = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_mmio_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_riscv_mmio_uart_tx
//
// Self-checking bench for riscv_mmio_uart_tx. Expected tx waveforms are built
// from the bytes and divisors alone: each frame is (div+1) clocks of start
// bit, eight data bits LSB-first, and a stop bit. Bus writes come from a
// per-clock script while a parallel process samples tx against that waveform.
// -----------------------------------------------------------------------------
module tb_riscv_mmio_uart_tx;

  localparam logic [31:0] BASE  = 32'hFFFF_FF00;
  localparam int          DEPTH = 8;
  localparam logic [31:0] A_TX  = BASE;
  localparam logic [31:0] A_ST  = BASE + 32'h4;
  localparam logic [31:0] A_BD  = BASE + 32'h8;
  localparam logic [31:0] A_RS  = BASE + 32'hC;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] addr  = '0;
  logic [31:0] wdata = '0;
  logic        we    = 1'b0;
  logic [31:0] rdata;
  logic        hit;
  logic        tx;
  logic        irq;

  riscv_mmio_uart_tx #(
    .BASE_ADDR  (BASE),
    .FIFO_DEPTH (DEPTH),
    .DEFAULT_DIV(16'd867)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .addr (addr),
    .wdata(wdata),
    .we   (we),
    .rdata(rdata),
    .hit  (hit),
    .tx   (tx),
    .irq  (irq)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Per-clock bus script and expected tx samples (one per clock, taken after
  // each edge starting with the edge of the first scripted cycle).
  logic        sc_we   [$];
  logic [31:0] sc_addr [$];
  logic [31:0] sc_data [$];
  bit          exp_wave[$];

  int r_mism, r_first, r_busy, r_irq_low;
  bit r_got, r_exp;

  // ---------------------------------------------------------------------------
  // Reference model pieces
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] status_word(input int cnt, input bit ovr, input bit bsy);
    logic [3:0] c;
    c = 4'(cnt);
    return {24'b0, c, ovr, bsy, (cnt == 0), (cnt == DEPTH)};
  endfunction

  // Idle line for the write edge and the pop edge before the start bit.
  function automatic void sc_reset();
    sc_we.delete();
    sc_addr.delete();
    sc_data.delete();
    exp_wave.delete();
    exp_wave.push_back(1'b1);
    exp_wave.push_back(1'b1);
  endfunction

  function automatic void sc_write(input logic [31:0] a, input logic [31:0] d);
    sc_we.push_back(1'b1);
    sc_addr.push_back(a);
    sc_data.push_back(d);
  endfunction

  function automatic void sc_idle();
    sc_we.push_back(1'b0);
    sc_addr.push_back(A_ST);
    sc_data.push_back('0);
  endfunction

  function automatic void add_frame(input logic [7:0] b, input int div);
    for (int k = 0; k <= div; k++) exp_wave.push_back(1'b0);
    for (int i = 0; i < 8; i++)
      for (int k = 0; k <= div; k++) exp_wave.push_back(b[i]);
    for (int k = 0; k <= div; k++) exp_wave.push_back(1'b1);
  endfunction

  function automatic void add_idle(input int n);
    for (int k = 0; k < n; k++) exp_wave.push_back(1'b1);
  endfunction

  // ---------------------------------------------------------------------------
  // Bus and capture tasks
  // ---------------------------------------------------------------------------
  task automatic write_reg(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    @(negedge clk);
    we    = 1'b0;
  endtask

  task automatic read_reg(input logic [31:0] a, output logic [31:0] d);
    addr = a;
    we   = 1'b0;
    #1;
    d = rdata;
  endtask

  task automatic drive_script();
    for (int i = 0; i < sc_we.size(); i++) begin
      addr  = sc_addr[i];
      wdata = sc_data[i];
      we    = sc_we[i];
      @(negedge clk);
    end
    we    = 1'b0;
    addr  = A_ST;
    wdata = '0;
  endtask

  // Called at a negedge just as the first scripted cycle is driven.
  task automatic capture_wave();
    int n;
    n         = exp_wave.size();
    r_mism    = 0;
    r_first   = -1;
    r_busy    = 0;
    r_irq_low = 0;
    @(posedge clk);
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      #1;
      if (addr == A_ST && rdata[2] === 1'b1) r_busy++;
      if (irq === 1'b0) r_irq_low++;
      if (tx !== exp_wave[j]) begin
        if (r_mism == 0) begin
          r_first = j;
          r_got   = tx;
          r_exp   = exp_wave[j];
        end
        r_mism++;
      end
    end
  endtask

  task automatic run_script();
    @(negedge clk);
    fork
      drive_script();
      capture_wave();
    join
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (tx !== 1'b1) begin
      failures++;
      $display("FAIL reset_tx_during: got %b want 1", tx);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (tx !== 1'b1 || irq !== 1'b1) begin
      failures++;
      $display("FAIL reset_tx_irq: got tx=%b irq=%b want tx=1 irq=1", tx, irq);
    end
    read_reg(A_ST, d);
    checks++;
    if (d !== 32'h0000_0002) begin
      failures++;
      $display("FAIL reset_status: got %h want 00000002", d);
    end
    read_reg(A_BD, d);
    checks++;
    if (d !== 32'd867) begin
      failures++;
      $display("FAIL reset_bauddiv: got %0d want 867", d);
    end
    read_reg(32'h0000_0000, d);
    checks++;
    if (hit !== 1'b0 || d !== 32'h0) begin
      failures++;
      $display("FAIL reset_addr0: got hit=%b rdata=%h want hit=0 rdata=0", hit, d);
    end
    read_reg(A_TX, d);
    checks++;
    if (hit !== 1'b1 || d !== 32'h0) begin
      failures++;
      $display("FAIL read_txdata: got hit=%b rdata=%h want hit=1 rdata=0", hit, d);
    end
    read_reg(A_RS, d);
    checks++;
    if (hit !== 1'b1 || d !== 32'h0) begin
      failures++;
      $display("FAIL read_reserved: got hit=%b rdata=%h want hit=1 rdata=0", hit, d);
    end
  endtask

  task automatic test_single_frame();
    logic [31:0] d;
    write_reg(A_BD, 32'hABCD_0003);
    read_reg(A_BD, d);
    checks++;
    if (d !== 32'h0000_0003) begin
      failures++;
      $display("FAIL bauddiv_upper: got %h want 00000003", d);
    end
    sc_reset();
    sc_write(A_TX, 32'h0000_0055);
    add_frame(8'h55, 3);
    add_idle(1);
    run_script();
    checks++;
    if (r_mism !== 0) begin
      failures++;
      $display("FAIL single_wave: %0d bad samples, first at %0d got %b want %b",
               r_mism, r_first, r_got, r_exp);
    end
    checks++;
    if (r_busy !== 40) begin
      failures++;
      $display("FAIL single_busy: got %0d busy clocks want 40", r_busy);
    end
    // irq is registered: it drops one clock after the push (FIFO non-empty)
    // and rises one clock after the shifter goes idle, so 40 + 1 clocks low.
    checks++;
    if (r_irq_low !== 41) begin
      failures++;
      $display("FAIL single_irq: got %0d irq-low clocks want 41", r_irq_low);
    end
    read_reg(A_ST, d);
    checks++;
    if (d !== 32'h0000_0002 || irq !== 1'b1) begin
      failures++;
      $display("FAIL single_after: got status=%h irq=%b want 00000002 irq=1", d, irq);
    end
  endtask

  task automatic test_back_to_back();
    write_reg(A_BD, 32'd1);
    sc_reset();
    sc_write(A_TX, 32'h0000_00A5);
    sc_write(A_TX, 32'h0000_003C);
    add_frame(8'hA5, 1);
    add_frame(8'h3C, 1);
    add_idle(1);
    run_script();
    checks++;
    if (r_mism !== 0) begin
      failures++;
      $display("FAIL b2b_wave: %0d bad samples, first at %0d got %b want %b",
               r_mism, r_first, r_got, r_exp);
    end
  endtask

  task automatic test_div_change();
    write_reg(A_BD, 32'd2);
    sc_reset();
    sc_write(A_TX, 32'h0000_00C6);
    sc_idle();
    sc_idle();
    sc_idle();
    sc_write(A_BD, 32'd5);       // lands mid-frame: first frame keeps div 2
    sc_write(A_TX, 32'h0000_0019);
    add_frame(8'hC6, 2);
    add_frame(8'h19, 5);
    add_idle(1);
    run_script();
    checks++;
    if (r_mism !== 0) begin
      failures++;
      $display("FAIL divchange_wave: %0d bad samples, first at %0d got %b want %b",
               r_mism, r_first, r_got, r_exp);
    end
  endtask

  task automatic test_overrun();
    logic [7:0]  bytes [9];
    logic [31:0] d;
    write_reg(A_BD, 32'd100);
    sc_reset();
    for (int i = 0; i < 9; i++) begin
      bytes[i] = 8'($urandom);
      add_frame(bytes[i], 100);
    end
    add_idle(1);
    @(negedge clk);
    fork
      begin
        for (int i = 0; i < 9; i++) begin
          addr  = A_TX;
          wdata = {24'h0, bytes[i]};
          we    = 1'b1;
          @(negedge clk);
        end
        // One byte is in the shifter, eight wait in the FIFO.
        we   = 1'b0;
        addr = A_ST;
        #1;
        checks++;
        if (rdata !== status_word(8, 1'b0, 1'b1)) begin
          failures++;
          $display("FAIL ovr_full: got %h want %h", rdata, status_word(8, 1'b0, 1'b1));
        end
        addr  = A_TX;
        wdata = 32'h0000_00EE;
        we    = 1'b1;
        @(negedge clk);
        we   = 1'b0;
        addr = A_ST;
        #1;
        checks++;
        if (rdata !== status_word(8, 1'b1, 1'b1)) begin
          failures++;
          $display("FAIL ovr_set: got %h want %h", rdata, status_word(8, 1'b1, 1'b1));
        end
        wdata = 32'hFFFF_FFF7;
        we    = 1'b1;
        @(negedge clk);
        we = 1'b0;
        #1;
        checks++;
        if (rdata !== status_word(8, 1'b1, 1'b1)) begin
          failures++;
          $display("FAIL ovr_noclear: got %h want %h", rdata, status_word(8, 1'b1, 1'b1));
        end
        wdata = 32'h0000_0008;
        we    = 1'b1;
        @(negedge clk);
        we = 1'b0;
        #1;
        checks++;
        if (rdata !== status_word(8, 1'b0, 1'b1)) begin
          failures++;
          $display("FAIL ovr_clear: got %h want %h", rdata, status_word(8, 1'b0, 1'b1));
        end
      end
      capture_wave();
    join
    checks++;
    if (r_mism !== 0) begin
      failures++;
      $display("FAIL ovr_wave: %0d bad samples, first at %0d got %b want %b",
               r_mism, r_first, r_got, r_exp);
    end
    read_reg(A_ST, d);
    checks++;
    if (d !== status_word(0, 1'b0, 1'b0)) begin
      failures++;
      $display("FAIL ovr_drained: got %h want %h", d, status_word(0, 1'b0, 1'b0));
    end
  endtask

  task automatic test_random();
    logic [31:0] d;
    int          div;
    int          n;
    logic [7:0]  b;
    for (int t = 0; t < 3; t++) begin
      div = $urandom_range(0, 4);
      n   = $urandom_range(2, DEPTH);
      write_reg(A_BD, 32'(div));
      read_reg(A_BD, d);
      checks++;
      if (d !== 32'(div)) begin
        failures++;
        $display("FAIL rand_bauddiv[%0d]: got %0d want %0d", t, d, div);
      end
      sc_reset();
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        sc_write(A_TX, {24'h0, b});
        add_frame(b, div);
      end
      add_idle(2);
      run_script();
      checks++;
      if (r_mism !== 0) begin
        failures++;
        $display("FAIL rand_wave[%0d] div=%0d n=%0d: %0d bad samples, first at %0d got %b want %b",
                 t, div, n, r_mism, r_first, r_got, r_exp);
      end
      read_reg(A_ST, d);
      checks++;
      if (d !== status_word(0, 1'b0, 1'b0) || irq !== 1'b1) begin
        failures++;
        $display("FAIL rand_after[%0d]: got status=%h irq=%b want %h irq=1",
                 t, d, irq, status_word(0, 1'b0, 1'b0));
      end
    end
  endtask

  task automatic test_bad_addr();
    logic [31:0] d;
    int          lows;
    write_reg(A_BD, 32'd2);
    write_reg(32'h0000_0000, 32'h0000_0041);
    write_reg(BASE + 32'h10, 32'h0000_0042);
    write_reg(A_RS, 32'h0000_0043);
    read_reg(BASE + 32'h10, d);
    checks++;
    if (hit !== 1'b0 || d !== 32'h0) begin
      failures++;
      $display("FAIL bad_next_window: got hit=%b rdata=%h want hit=0 rdata=0", hit, d);
    end
    read_reg(32'h0000_0000, d);
    checks++;
    if (hit !== 1'b0 || d !== 32'h0) begin
      failures++;
      $display("FAIL bad_zero: got hit=%b rdata=%h want hit=0 rdata=0", hit, d);
    end
    read_reg(A_RS, d);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL bad_reserved: got %h want 0", d);
    end
    read_reg(A_BD, d);
    checks++;
    if (d !== 32'd2) begin
      failures++;
      $display("FAIL bad_bauddiv: got %0d want 2", d);
    end
    read_reg(A_ST, d);
    checks++;
    if (d !== 32'h0000_0002) begin
      failures++;
      $display("FAIL bad_status: got %h want 00000002", d);
    end
    lows = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    checks++;
    if (lows !== 0) begin
      failures++;
      $display("FAIL bad_tx_quiet: got %0d non-idle clocks want 0", lows);
    end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] d;
    int          lows;
    write_reg(A_BD, 32'd7);
    write_reg(A_TX, 32'h0000_00F0);
    // Now one clock past the write edge; bit 3 occupies samples 34..41.
    repeat (36) @(negedge clk);
    #1;
    checks++;
    if (tx !== 1'b0) begin
      failures++;
      $display("FAIL mid_bit3: got %b want 0", tx);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (tx !== 1'b1 || irq !== 1'b1) begin
      failures++;
      $display("FAIL mid_async: got tx=%b irq=%b want tx=1 irq=1", tx, irq);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    read_reg(A_ST, d);
    checks++;
    if (d !== 32'h0000_0002) begin
      failures++;
      $display("FAIL mid_status: got %h want 00000002", d);
    end
    read_reg(A_BD, d);
    checks++;
    if (d !== 32'd867) begin
      failures++;
      $display("FAIL mid_bauddiv: got %0d want 867", d);
    end
    lows = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    checks++;
    if (lows !== 0) begin
      failures++;
      $display("FAIL mid_quiet: got %0d non-idle clocks want 0", lows);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequencer and watchdog
  // ---------------------------------------------------------------------------
  initial begin
    #2;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_div_change();
    test_overrun();
    test_random();
    test_bad_addr();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
